// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared register map, status layout, FSM states and float constants
package conv_pkg;

    localparam logic [31:0] OFF_WEIGHT = 32'h00;
    localparam logic [31:0] OFF_PIXEL  = 32'h04;
    localparam logic [31:0] OFF_BIAS   = 32'h08;
    localparam logic [31:0] OFF_CTRL   = 32'h0C;
    localparam logic [31:0] OFF_STATUS = 32'h10;
    localparam logic [31:0] OFF_RESULT = 32'h14;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_ERR      = 2;
    localparam int STAT_WLOADED  = 3;
    localparam int STAT_WCNT_LSB = 8;
    localparam int STAT_PCNT_LSB = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [31:0] FP_ONE = 32'h3F800000;
    localparam logic [31:0] FP_TWO = 32'h40000000;

endpackage

// File: rtl/conv_fma_sequencer_if.sv
// rtl/conv_fma_sequencer_if.sv - device bus between the CPU side and the sequencer
interface conv_fma_sequencer_if #(
    parameter int XLEN = 32
);
    logic            en_i;
    logic            we_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] data_i;
    logic            ready_o;
    logic [XLEN-1:0] data_o;

    modport master (
        output en_i, we_i, addr_i, data_i,
        input  ready_o, data_o
    );

    modport slave (
        input  en_i, we_i, addr_i, data_i,
        output ready_o, data_o
    );
endinterface

// File: rtl/conv_tap_buffer.sv
// rtl/conv_tap_buffer.sv - weight/pixel register files with write pointers and indexed read
module conv_tap_buffer #(
    parameter int XLEN  = 32,
    parameter int TAPS  = 25,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             w_we,
    input  logic             p_we,
    input  logic             clear,
    input  logic             p_rst,
    input  logic [XLEN-1:0]  wdata,
    input  logic [CNT_W-1:0] rd_idx,
    output logic [XLEN-1:0]  w_rd,
    output logic [XLEN-1:0]  p_rd,
    output logic [CNT_W-1:0] wcnt,
    output logic [CNT_W-1:0] pcnt,
    output logic             w_loaded,
    output logic             p_full
);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] TAPS_C = CNT_W'(TAPS);

    logic [XLEN-1:0] w_mem [TAPS];
    logic [XLEN-1:0] p_mem [TAPS];

    assign p_full = (pcnt == TAPS_C);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt     <= '0;
            pcnt     <= '0;
            w_loaded <= 1'b0;
        end else if (clear || p_rst) begin
            if (clear) wcnt <= '0;
            pcnt <= '0;
        end else begin
            if (w_we) begin
                if (wcnt == LAST) begin
                    wcnt     <= '0;
                    w_loaded <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            // A full pixel file drops the write; the top flags the error.
            if (p_we && !p_full) pcnt <= pcnt + 1'b1;
        end
    end

    // Storage is not reset: the counters and w_loaded gate every use of it.
    always_ff @(posedge clk_i) begin
        if (w_we) w_mem[wcnt] <= wdata;
        if (p_we && !p_full) p_mem[pcnt] <= wdata;
    end

    assign w_rd = (rd_idx < TAPS_C) ? w_mem[rd_idx] : '0;
    assign p_rd = (rd_idx < TAPS_C) ? p_mem[rd_idx] : '0;

endmodule

// File: rtl/conv_fma_sequencer.sv
// rtl/conv_fma_sequencer.sv - MMIO controller chaining TAPS fused multiply-adds per window
module conv_fma_sequencer
    import conv_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'hC4300000,
    parameter int              TAPS      = 25,
    parameter int              TIMEOUT   = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    conv_fma_sequencer_if.slave bus,
    output logic                fma_valid_o,
    output logic [XLEN-1:0]     fma_a_o,
    output logic [XLEN-1:0]     fma_b_o,
    output logic [XLEN-1:0]     fma_c_o,
    input  logic                fma_res_valid_i,
    input  logic [XLEN-1:0]     fma_res_i,
    output logic                irq_o
);
    localparam int               CNT_W    = $clog2(TAPS + 1);
    localparam int               TIM_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TAPS - 1);
    localparam logic [TIM_W-1:0] TIM_LAST = TIM_W'(TIMEOUT - 1);

    state_e           state;
    logic             busy, done, err;
    logic [CNT_W-1:0] idx, rd_idx;
    logic [TIM_W-1:0] timer;
    logic [XLEN-1:0]  bias, result;

    logic [XLEN-1:0]  off;
    logic             wr_ok, w_we, p_we, bias_we, ctrl_we, clear, p_rst, timed_out;
    logic [XLEN-1:0]  w_rd, p_rd;
    logic [CNT_W-1:0] wcnt, pcnt;
    logic             w_loaded, p_full;
    logic [XLEN-1:0]  status_word, rd_word;

    assign off     = bus.addr_i - BASE_ADDR;
    assign wr_ok   = bus.en_i && bus.we_i && !busy;
    assign w_we    = wr_ok && (off == OFF_WEIGHT);
    assign p_we    = wr_ok && (off == OFF_PIXEL);
    assign bias_we = wr_ok && (off == OFF_BIAS);
    assign ctrl_we = wr_ok && (off == OFF_CTRL);
    assign clear   = ctrl_we && bus.data_i[CTRL_CLEAR];

    assign timed_out = (state == S_WAIT) && !fma_res_valid_i && (timer == TIM_LAST);
    assign p_rst     = (state == S_DONE) || timed_out;

    // Operands are registered one step ahead, so the read port looks at the next tap.
    assign rd_idx = (state == S_IDLE) ? '0 : idx + 1'b1;

    conv_tap_buffer #(
        .XLEN  (XLEN),
        .TAPS  (TAPS),
        .CNT_W (CNT_W)
    ) u_taps (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .w_we     (w_we),
        .p_we     (p_we),
        .clear    (clear),
        .p_rst    (p_rst),
        .wdata    (bus.data_i),
        .rd_idx   (rd_idx),
        .w_rd     (w_rd),
        .p_rd     (p_rd),
        .wcnt     (wcnt),
        .pcnt     (pcnt),
        .w_loaded (w_loaded),
        .p_full   (p_full)
    );

    always_comb begin
        status_word = '0;
        status_word[STAT_BUSY]    = busy;
        status_word[STAT_DONE]    = done;
        status_word[STAT_ERR]     = err;
        status_word[STAT_WLOADED] = w_loaded;
        status_word[STAT_WCNT_LSB +: 5] = 5'(wcnt);
        status_word[STAT_PCNT_LSB +: 5] = 5'(pcnt);
    end

    always_comb begin
        rd_word = '0;
        if (off == OFF_STATUS)      rd_word = status_word;
        else if (off == OFF_RESULT) rd_word = result;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.ready_o <= 1'b0;
            bus.data_o  <= '0;
        end else begin
            bus.ready_o <= bus.en_i;
            bus.data_o  <= (bus.en_i && !bus.we_i) ? rd_word : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            idx         <= '0;
            timer       <= '0;
            bias        <= '0;
            result      <= '0;
            fma_valid_o <= 1'b0;
            fma_a_o     <= '0;
            fma_b_o     <= '0;
            fma_c_o     <= '0;
        end else begin
            if (bias_we) bias <= bus.data_i;
            if (p_we && p_full) err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (ctrl_we) begin
                        if (clear) begin
                            done <= 1'b0;
                            err  <= 1'b0;
                        end
                        // CLEAR empties the pixel file first, so a combined START must fail.
                        if (bus.data_i[CTRL_START]) begin
                            if (w_loaded && p_full && !clear) begin
                                fma_valid_o <= 1'b1;
                                fma_a_o     <= w_rd;
                                fma_b_o     <= p_rd;
                                fma_c_o     <= bias;
                                idx         <= '0;
                                busy        <= 1'b1;
                                done        <= 1'b0;
                                err         <= 1'b0;
                                state       <= S_ISSUE;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                end

                S_ISSUE: begin
                    fma_valid_o <= 1'b0;
                    timer       <= '0;
                    state       <= S_WAIT;
                end

                S_WAIT: begin
                    if (fma_res_valid_i) begin
                        fma_c_o <= fma_res_i;
                        if (idx == LAST) begin
                            state <= S_DONE;
                        end else begin
                            idx         <= idx + 1'b1;
                            fma_valid_o <= 1'b1;
                            fma_a_o     <= w_rd;
                            fma_b_o     <= p_rd;
                            state       <= S_ISSUE;
                        end
                    end else if (timer == TIM_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_DONE: begin
                    result <= fma_c_o;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign irq_o = done;

endmodule

// File: tb/tb_conv_fma_sequencer.sv
// tb/tb_conv_fma_sequencer.sv - self-checking bench with a real-arithmetic FMA and window model
module tb_conv_fma_sequencer;
    import conv_pkg::*;

    localparam int          TAPS = 25;
    localparam logic [31:0] BASE = 32'hC4300000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fma_valid, irq;
    logic [31:0] fa, fb, fc;
    logic        res_valid = 1'b0;
    logic [31:0] res = '0;

    always #5 clk = ~clk;

    conv_fma_sequencer_if bus ();

    conv_fma_sequencer dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .bus             (bus),
        .fma_valid_o     (fma_valid),
        .fma_a_o         (fa),
        .fma_b_o         (fb),
        .fma_c_o         (fc),
        .fma_res_valid_i (res_valid),
        .fma_res_i       (res),
        .irq_o           (irq)
    );

    int checks = 0;
    int errors = 0;

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:0] == 31'd0) return 0.0;
        e = int'(f[30:23]) - 127;
        m = (1.0 + real'(int'(f[22:0])) / 8388608.0) * (2.0 ** e);
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic s;
        int   e;
        real  x;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        x = s ? -r : r;
        e = 0;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0)  begin x = x * 2.0; e--; end
        return {s, 8'(e + 127), 23'($rtoi((x - 1.0) * 8388608.0 + 0.5))};
    endfunction

    // FMA model: latency counted in cycles from the issue cycle to the result cycle.
    bit          respond = 1'b1;
    int          lat = 4;
    int          pulses = 0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_res = '0;

    always begin
        @(negedge clk);
        res_valid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                res_valid = 1'b1;
                res       = pend_res;
                pend      = 1'b0;
            end
        end
        if (fma_valid) begin
            pulses++;
            if (respond) begin
                pend     = 1'b1;
                pend_cnt = lat;
                pend_res = r2f(f2r(fa) * f2r(fb) + f2r(fc));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int          wi [TAPS];
    int          pi [TAPS];
    int          bias_i;
    logic [31:0] last_res;
    time         t_ack;

    task automatic bus_write(input logic [31:0] ad, input logic [31:0] d, output logic rdy);
        @(negedge clk);
        bus.en_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = ad; bus.data_i = d;
        @(posedge clk); #1;
        rdy = bus.ready_o;
        bus.en_i = 1'b0; bus.we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] ad, output logic [31:0] d, output logic rdy);
        @(negedge clk);
        bus.en_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = ad;
        @(posedge clk); #1;
        rdy = bus.ready_o;
        d   = bus.data_o;
        bus.en_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        logic r;
        bus_write(BASE + off, d, r);
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        logic r;
        bus_read(BASE + off, d, r);
    endtask

    task automatic load_w();
        for (int i = 0; i < TAPS; i++) wr(OFF_WEIGHT, r2f(real'(wi[i])));
    endtask

    task automatic load_p(input int n);
        for (int i = 0; i < n; i++) wr(OFF_PIXEL, r2f(real'(pi[i])));
    endtask

    task automatic fill(input int w, input int p, input int b);
        for (int i = 0; i < TAPS; i++) begin wi[i] = w; pi[i] = p; end
        bias_i = b;
    endtask

    task automatic randomize_window();
        for (int i = 0; i < TAPS; i++) begin
            wi[i] = int'($urandom_range(0, 3));
            pi[i] = int'($urandom_range(0, 3));
        end
        bias_i = int'($urandom_range(0, 7));
    endtask

    function automatic logic [31:0] expected_sum();
        int s = bias_i;
        for (int i = 0; i < TAPS; i++) s += wi[i] * pi[i];
        return r2f(real'(s));
    endfunction

    task automatic start_run();
        wr(OFF_CTRL, 32'h1);
        t_ack = $time;
    endtask

    task automatic run_wait(output int cyc);
        int n = 0;
        while (!irq && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        cyc = int'(($time - t_ack) / 10);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic r;
        bus.en_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({fma_valid, irq, bus.ready_o, fa, fb, fc, bus.data_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b irq=%b ready=%b a=%h b=%h c=%h data=%h, want all 0",
                     fma_valid, irq, bus.ready_o, fa, fb, fc, bus.data_o);
        end
        @(negedge clk); rst_n = 1'b1;
        bus_read(BASE + OFF_STATUS, d, r);
        checks++;
        if (d !== 32'h0 || r !== 1'b1) begin
            errors++; $display("FAIL reset_status: got %h ready=%b want 00000000 ready=1", d, r);
        end
        rd(OFF_RESULT, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        int cyc, p0;
        lat = 4; respond = 1'b1;
        fill(1, 2, 0);
        load_w();
        wr(OFF_BIAS, 32'h0);
        load_p(TAPS);
        rd(OFF_STATUS, d);
        checks++;
        if (d !== 32'h00190008) begin errors++; $display("FAIL basic_loaded_status: got %h want 00190008", d); end
        p0 = pulses;
        start_run();
        run_wait(cyc);
        checks++;
        if (cyc != TAPS * (lat + 1) + 1) begin
            errors++; $display("FAIL basic_latency: got %0d want %0d", cyc, TAPS * (lat + 1) + 1);
        end
        checks++;
        if (pulses - p0 != TAPS) begin errors++; $display("FAIL basic_pulses: got %0d want %0d", pulses - p0, TAPS); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq: got %b want 1", irq); end
        rd(OFF_STATUS, d);
        checks++;
        if (d !== 32'h0000000A) begin errors++; $display("FAIL basic_done_status: got %h want 0000000a", d); end
        rd(OFF_RESULT, d);
        checks++;
        if (d !== 32'h42480000) begin errors++; $display("FAIL basic_result: got %h want 42480000", d); end
        last_res = 32'h42480000;
    endtask

    task automatic test_short_overflow();
        logic [31:0] d;
        logic r;
        int cyc, p0;
        randomize_window();
        load_w();
        wr(OFF_BIAS, r2f(real'(bias_i)));
        load_p(TAPS - 1);
        p0 = pulses;
        start_run();
        repeat (8) @(posedge clk);
        rd(OFF_STATUS, d);
        checks++;
        if (d !== 32'h0018000E) begin errors++; $display("FAIL short_status: got %h want 0018000e", d); end
        checks++;
        if (pulses != p0) begin errors++; $display("FAIL short_no_issue: got %0d pulses want 0", pulses - p0); end
        wr(OFF_PIXEL, r2f(real'(pi[TAPS-1])));
        bus_write(BASE + OFF_PIXEL, 32'h47000000, r);
        checks++;
        if (r !== 1'b1) begin errors++; $display("FAIL overflow_ready: got %b want 1", r); end
        rd(OFF_STATUS, d);
        checks++;
        if (d !== 32'h0019000E) begin errors++; $display("FAIL overflow_status: got %h want 0019000e", d); end
        start_run();
        run_wait(cyc);
        checks++;
        if (cyc != TAPS * (lat + 1) + 1) begin
            errors++; $display("FAIL short_latency: got %0d want %0d", cyc, TAPS * (lat + 1) + 1);
        end
        rd(OFF_RESULT, d);
        checks++;
        if (d !== expected_sum()) begin errors++; $display("FAIL short_result: got %h want %h", d, expected_sum()); end
        last_res = expected_sum();
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        int p0;
        respond = 1'b0;
        load_p(TAPS);
        p0 = pulses;
        start_run();
        repeat (64) @(posedge clk);
        rd(OFF_STATUS, d);
        checks++;
        if (d !== 32'h00190009) begin errors++; $display("FAIL timeout_still_busy: got %h want 00190009", d); end
        rd(OFF_STATUS, d);
        checks++;
        if (d !== 32'h0000000C) begin errors++; $display("FAIL timeout_status: got %h want 0000000c", d); end
        rd(OFF_RESULT, d);
        checks++;
        if (d !== last_res) begin errors++; $display("FAIL timeout_result_kept: got %h want %h", d, last_res); end
        checks++;
        if (pulses - p0 != 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", pulses - p0); end
        respond = 1'b1;
    endtask

    task automatic test_start_clear();
        logic [31:0] d;
        int p0;
        load_p(TAPS);
        p0 = pulses;
        wr(OFF_CTRL, 32'h3);
        repeat (5) @(posedge clk);
        rd(OFF_STATUS, d);
        checks++;
        if (d !== 32'h0000000C || pulses != p0) begin
            errors++; $display("FAIL start_clear: got status %h pulses %0d want 0000000c pulses 0", d, pulses - p0);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic r;
        bus_read(BASE + 32'h18, d, r);
        checks++;
        if (d !== 32'h0 || r !== 1'b1) begin errors++; $display("FAIL unmapped_read: got %h ready=%b want 0 ready=1", d, r); end
        #10;
        checks++;
        if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL ready_pulse_width: got %b want 0", bus.ready_o); end
        bus_write(BASE + 32'h40, 32'hFFFFFFFF, r);
        bus_read(BASE - 32'h4, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL below_base_read: got %h want 0", d); end
        rd(OFF_STATUS, d);
        checks++;
        if (d !== 32'h0000000C) begin errors++; $display("FAIL unmapped_write_ignored: got %h want 0000000c", d); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d;
        int n, p0;
        lat = 4;
        load_p(TAPS);
        p0 = pulses;
        start_run();
        n = 0;
        while (pulses - p0 < 11 && n < 1000) begin @(posedge clk); #1; n++; end
        checks++;
        if (pulses - p0 != 11) begin errors++; $display("FAIL midrun_reach_tap10: got %0d pulses want 11", pulses - p0); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fma_valid, irq, bus.ready_o, fa, fb, fc, bus.data_o} !== '0) begin
            errors++; $display("FAIL midrun_async_reset: got valid=%b a=%h b=%h c=%h, want all 0", fma_valid, fa, fb, fc);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        p0 = pulses;
        repeat (8) @(posedge clk);
        rd(OFF_STATUS, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL midrun_status_after: got %h want 00000000", d); end
        rd(OFF_RESULT, d);
        checks++;
        if (d !== 32'h0 || pulses != p0 || irq !== 1'b0) begin
            errors++; $display("FAIL midrun_late_result: got result %h pulses %0d irq %b want 0 0 0", d, pulses - p0, irq);
        end
        last_res = 32'h0;
    endtask

    task automatic test_twice();
        logic [31:0] d;
        int cyc;
        fill(1, 1, 1);
        load_w();
        wr(OFF_BIAS, FP_ONE);
        for (int run = 0; run < 2; run++) begin
            load_p(TAPS);
            start_run();
            run_wait(cyc);
            rd(OFF_RESULT, d);
            checks++;
            if (d !== 32'h41D00000) begin errors++; $display("FAIL twice_result_%0d: got %h want 41d00000", run, d); end
        end
        rd(OFF_STATUS, d);
        checks++;
        if (d !== 32'h0000000A) begin errors++; $display("FAIL twice_status: got %h want 0000000a", d); end
        last_res = 32'h41D00000;
    endtask

    task automatic test_random();
        logic [31:0] d;
        int cyc;
        for (int it = 0; it < 3; it++) begin
            lat = int'($urandom_range(1, 6));
            randomize_window();
            load_w();
            wr(OFF_BIAS, r2f(real'(bias_i)));
            load_p(TAPS);
            start_run();
            wr(OFF_CTRL, 32'h2);
            wr(OFF_WEIGHT, FP_TWO);
            wr(OFF_BIAS, 32'h42C80000);
            rd(OFF_RESULT, d);
            checks++;
            if (d !== last_res) begin errors++; $display("FAIL random_busy_result_%0d: got %h want %h", it, d, last_res); end
            run_wait(cyc);
            checks++;
            if (cyc != TAPS * (lat + 1) + 1) begin
                errors++; $display("FAIL random_latency_%0d: got %0d want %0d", it, cyc, TAPS * (lat + 1) + 1);
            end
            rd(OFF_RESULT, d);
            checks++;
            if (d !== expected_sum()) begin errors++; $display("FAIL random_result_%0d: got %h want %h", it, d, expected_sum()); end
            rd(OFF_STATUS, d);
            checks++;
            if (d !== 32'h0000000A) begin errors++; $display("FAIL random_status_%0d: got %h want 0000000a", it, d); end
            last_res = expected_sum();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_overflow();
        test_timeout();
        test_start_clear();
        test_unmapped();
        test_reset_mid_run();
        test_twice();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
